fifo_sync_param: RTL and testbench

//  Parametrised single-clock FIFO; next generation of the team's basic sync FIFO.

---
 rtl/fifo_sync_param.sv | 104 ++++++++++
 tb/tb_fifo_sync_param.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with thresholds, occupancy and FWFT mode
// Optional sticky overflow/underflow flags with err_clr are enabled by defining FIFO_ERR_FLAGS_EN.
module fifo_sync_param #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AF_THRESH  = 6,
   parameter int AE_THRESH  = 2,
   parameter int FWFT       = 0
) (
   input  logic                         clk,
   input  logic                         rst,
`ifdef FIFO_ERR_FLAGS_EN
   input  logic                         err_clr,
   output logic                         overflow,
   output logic                         underflow,
`endif
   input  logic                         cs,
   input  logic                         wr_en,
   input  logic                         rd_en,
   input  logic [DATA_WIDTH-1:0]        data_in,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count_q;
   logic                  rd_acc;
   logic                  wr_acc;

   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AF_THRESH));
   assign almost_empty = (count_q <= CW'(AE_THRESH));
   assign count        = count_q;

   // A write into a full FIFO is accepted only when a read frees the head slot in the same cycle.
   assign rd_acc = cs & rd_en & ~empty;
   assign wr_acc = cs & wr_en & (~full | rd_acc);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         if (wr_acc && !rd_acc)      count_q <= count_q + CW'(1);
         else if (rd_acc && !wr_acc) count_q <= count_q - CW'(1);
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) mem[wr_ptr] <= data_in;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         always_comb begin
            data_out = '0;
            if (!empty) data_out = mem[rd_ptr];
         end
      end else begin : g_std
         logic [DATA_WIDTH-1:0] dout_q;
         always_ff @(posedge clk) begin
            if (rst)         dout_q <= '0;
            else if (rd_acc) dout_q <= mem[rd_ptr];
         end
         assign data_out = dout_q;
      end
   endgenerate

`ifdef FIFO_ERR_FLAGS_EN
   logic ovf_q;
   logic udf_q;

   // Setting takes priority over err_clr so an error in the clearing cycle is never lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (cs && wr_en && !wr_acc) ovf_q <= 1'b1;
         else if (err_clr)           ovf_q <= 1'b0;
         if (cs && rd_en && empty)   udf_q <= 1'b1;
         else if (err_clr)           udf_q <= 1'b0;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - self-checking bench for fifo_sync_param, standard and FWFT instances
// Define FIFO_ERR_FLAGS_EN to also check the sticky overflow/underflow flags.
module tb_fifo_sync_param;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cs = 1'b0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic          err_clr = 1'b0;
   logic [DW-1:0] data_in = '0;

   logic [DW-1:0] dout_s, dout_f;
   logic          full_s, empty_s, af_s, ae_s;
   logic          full_f, empty_f, af_f, ae_f;
   logic [3:0]    count_s, count_f;
`ifdef FIFO_ERR_FLAGS_EN
   logic          ovf_s, udf_s, ovf_f, udf_f;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model: a queue of stored words plus the registered read word and sticky flags.
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout = '0;
   logic          m_ovf = 1'b0;
   logic          m_udf = 1'b0;

   always #5 clk = ~clk;

   fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
      .clk(clk), .rst(rst),
`ifdef FIFO_ERR_FLAGS_EN
      .err_clr(err_clr), .overflow(ovf_s), .underflow(udf_s),
`endif
      .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(dout_s),
      .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s), .count(count_s)
   );

   fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fw (
      .clk(clk), .rst(rst),
`ifdef FIFO_ERR_FLAGS_EN
      .err_clr(err_clr), .overflow(ovf_f), .underflow(udf_f),
`endif
      .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(dout_f),
      .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f), .count(count_f)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic c, input logic w, input logic rd,
                       input logic [DW-1:0] d, input logic ec);
      bit ra, wa;
      int n;
      logic [DW-1:0] exp_fw;
      rst = r; cs = c; wr_en = w; rd_en = rd; data_in = d; err_clr = ec;
      @(posedge clk);
      if (r) begin
         q.delete();
         m_dout = '0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
      end else begin
         ra = c && rd && (q.size() != 0);
         wa = c && w && ((q.size() < DEPTH) || ra);
         if (c && w && !wa)           m_ovf = 1'b1;
         else if (ec)                 m_ovf = 1'b0;
         if (c && rd && q.size() == 0) m_udf = 1'b1;
         else if (ec)                 m_udf = 1'b0;
         if (ra) m_dout = q.pop_front();
         if (wa) q.push_back(d);
      end
      #1;
      n = q.size();
      exp_fw = (n != 0) ? q[0] : '0;
      chk("count_std", 32'(count_s), 32'(n));
      chk("count_fwft", 32'(count_f), 32'(n));
      chk("empty", {30'd0, empty_s, empty_f}, {30'd0, n == 0, n == 0});
      chk("full", {30'd0, full_s, full_f}, {30'd0, n == DEPTH, n == DEPTH});
      chk("almost_full", {30'd0, af_s, af_f}, {30'd0, n >= AF, n >= AF});
      chk("almost_empty", {30'd0, ae_s, ae_f}, {30'd0, n <= AE, n <= AE});
      chk("data_out_std", 32'(dout_s), 32'(m_dout));
      chk("data_out_fwft", 32'(dout_f), 32'(exp_fw));
`ifdef FIFO_ERR_FLAGS_EN
      chk("overflow", {30'd0, ovf_s, ovf_f}, {30'd0, m_ovf, m_ovf});
      chk("underflow", {30'd0, udf_s, udf_f}, {30'd0, m_udf, m_udf});
`endif
   endtask

   initial begin
      // Reset state, including a reset cycle with requests present.
      step(1, 0, 0, 0, 8'h00, 0);
      step(1, 1, 1, 1, 8'h99, 0);

      // Fill with 0x11..0x18 then drain in order.
      for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 8'(8'h11 + i), 0);
      for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 8'h00, 0);

      // Full with simultaneous write and read, then drain.
      for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 8'(8'h11 + i), 0);
      step(0, 1, 1, 1, 8'hAA, 0);
      for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 8'h00, 0);

      // Empty with simultaneous write and read: no bypass.
      step(0, 1, 1, 1, 8'h55, 0);
      step(0, 1, 0, 1, 8'h00, 0);

      // FWFT fall-through into an empty FIFO, chip select gating, underflow.
      step(0, 1, 1, 0, 8'h3C, 0);
      step(0, 1, 0, 0, 8'h00, 0);
      step(0, 0, 1, 1, 8'hEE, 0);
      step(0, 1, 0, 1, 8'h00, 0);
      step(0, 1, 0, 1, 8'h00, 0);
      step(0, 1, 0, 0, 8'h00, 1);

      // Overflow on a ninth write, held until err_clr.
      for (int i = 0; i < 9; i++) step(0, 1, 1, 0, 8'(8'hA0 + i), 0);
      step(0, 1, 0, 0, 8'h00, 0);
      step(0, 1, 0, 0, 8'h00, 0);
      step(0, 1, 1, 0, 8'hBB, 1);
      step(0, 1, 0, 0, 8'h00, 1);

      // Reset mid-operation with five entries and both requests asserted.
      step(1, 0, 0, 0, 8'h00, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 8'(8'h60 + i), 0);
      step(1, 1, 1, 1, 8'h77, 0);
      step(0, 1, 0, 0, 8'h00, 0);

      // Randomised traffic; pointers wrap several times.
      for (int i = 0; i < 120; i++)
         step(0, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 15) == 0));
      for (int i = 0; i < 9; i++) step(0, 1, 0, 1, 8'h00, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
